// File: rtl/gsm_cell_recycler.sv
// gsm_cell_recycler
//   Closes the cell-address loop between the output ports and the malloc stage.
//   Each allocated cell gets a reference count (popcount of its multicast
//   vector). Output ports return cells through a round-robin arbiter, one
//   release per cycle. When a count reaches zero the address is pushed into a
//   first-word-fall-through free FIFO that malloc drains via the hmp interface.
//
// Ports
//   clk, rst_n (async, active-low), clr (sync, same effect as reset)
//   i_gsm_wr_en / i_gsm_cell_addr / i_gsm_multicast : malloc write stream
//   i_rel_valid / i_rel_addr / o_rel_ready          : per-port release requests
//   i_hmp_rd / o_hmp_valid / o_hmp_addr             : free-address FIFO read side
//   o_bf_free_flag : one-cycle pulse per cell returned to the free pool
//   o_err          : sticky; [0] zero-count release, zero multicast or
//                    write/release collision, [1] push to a full FIFO
module gsm_cell_recycler #(
  parameter int MWIDTH     = 4,
  parameter int LOG_MWIDTH = 2,
  parameter int AWIDTH     = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     i_gsm_wr_en,
  input  logic [AWIDTH-1:0]        i_gsm_cell_addr,
  input  logic [MWIDTH-1:0]        i_gsm_multicast,
  input  logic [MWIDTH-1:0]        i_rel_valid,
  input  logic [MWIDTH*AWIDTH-1:0] i_rel_addr,
  output logic [MWIDTH-1:0]        o_rel_ready,
  input  logic                     i_hmp_rd,
  output logic                     o_hmp_valid,
  output logic [AWIDTH-1:0]        o_hmp_addr,
  output logic                     o_bf_free_flag,
  output logic [1:0]               o_err
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int CW    = LOG_MWIDTH + 1;

  function automatic logic [CW-1:0] f_popcount(input logic [MWIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < MWIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  logic [CW-1:0]         r_cnt [DEPTH];
  logic [AWIDTH-1:0]     r_mem [DEPTH];
  logic [AWIDTH-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AWIDTH:0]       r_occ;
  logic [LOG_MWIDTH-1:0] r_arb_ptr;
  logic                  r_free;
  logic [1:0]            r_err;

  logic [MWIDTH-1:0]     w_grant;
  logic [LOG_MWIDTH-1:0] w_win_idx;
  logic                  w_found;
  logic [AWIDTH-1:0]     w_rel_addr;
  logic [CW-1:0]         w_rel_cnt;
  logic                  w_collide, w_rel_do, w_rel_zero, w_push;
  logic                  w_wr_zero, w_pop, w_full, w_store, w_drop;

  // Round-robin search starting one past the last winner.
  always_comb begin
    int idx;
    w_grant   = '0;
    w_win_idx = r_arb_ptr;
    w_found   = 1'b0;
    for (int k = 1; k <= MWIDTH; k++) begin
      idx = (int'(r_arb_ptr) + k) % MWIDTH;
      if (!w_found && i_rel_valid[idx]) begin
        w_found   = 1'b1;
        w_win_idx = LOG_MWIDTH'(idx);
      end
    end
    if (w_found) w_grant[w_win_idx] = 1'b1;
  end

  assign w_rel_addr = i_rel_addr[int'(w_win_idx)*AWIDTH +: AWIDTH];
  assign w_rel_cnt  = r_cnt[w_rel_addr];

  // A release colliding with an allocation of the same cell is discarded:
  // the fresh allocation count must survive.
  assign w_collide  = i_gsm_wr_en && w_found && (i_gsm_cell_addr == w_rel_addr);
  assign w_rel_do   = w_found && !w_collide;
  assign w_rel_zero = w_rel_do && (w_rel_cnt == '0);
  assign w_push     = w_rel_do && (w_rel_cnt == CW'(1));
  assign w_wr_zero  = i_gsm_wr_en && (i_gsm_multicast == '0);

  // Pop is ignored when empty, so push+pop on empty just stores the push.
  assign w_pop   = i_hmp_rd && (r_occ != '0);
  assign w_full  = (r_occ == (AWIDTH+1)'(DEPTH));
  assign w_store = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_arb_ptr <= LOG_MWIDTH'(MWIDTH-1);
      r_free    <= 1'b0;
      r_err     <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_arb_ptr <= LOG_MWIDTH'(MWIDTH-1);
      r_free    <= 1'b0;
      r_err     <= '0;
    end else begin
      if (w_rel_do && (w_rel_cnt != '0)) r_cnt[w_rel_addr] <= w_rel_cnt - CW'(1);
      if (i_gsm_wr_en) r_cnt[i_gsm_cell_addr] <= f_popcount(i_gsm_multicast);
      if (w_found) r_arb_ptr <= w_win_idx;
      if (w_store) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      case ({w_store, w_pop})
        2'b10:   r_occ <= r_occ + (AWIDTH+1)'(1);
        2'b01:   r_occ <= r_occ - (AWIDTH+1)'(1);
        default: r_occ <= r_occ;
      endcase
      r_free   <= w_store;
      r_err[0] <= r_err[0] | w_rel_zero | w_wr_zero | w_collide;
      r_err[1] <= r_err[1] | w_drop;
    end
  end

  // FIFO storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= w_rel_addr;
  end

  assign o_rel_ready    = w_grant;
  assign o_hmp_valid    = (r_occ != '0);
  assign o_hmp_addr     = r_mem[r_rd_ptr];
  assign o_bf_free_flag = r_free;
  assign o_err          = r_err;

endmodule
